// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: tracks destination registers of in-flight instructions in
// the STAGES stages after ID, resolves the two ID read operands (regfile or
// forwarded stage result) and raises a load-use stall request.
//
// Flow control: hold=1 freezes every tracked entry and the stall counter.
// With hold=0 the tracker advances by one stage per clock. stall_req=1
// means the ID instruction is not accepted this cycle and a bubble enters
// stage 0. stall_req depends only on current inputs and pre-edge tracker
// state.
module pipe_scoreboard #(
    parameter int STAGES     = 3,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic                 id_we,
    input  logic [AW-1:0]        id_waddr,
    input  logic                 id_is_load,
    input  logic [AW-1:0]        rs_addr,
    input  logic [AW-1:0]        rt_addr,
    input  logic [DW-1:0]        rf_rs_data,
    input  logic [DW-1:0]        rf_rt_data,
    input  logic [STAGES*DW-1:0] stage_wdata,
    output logic [DW-1:0]        rs_data,
    output logic [DW-1:0]        rt_data,
    output logic                 rs_fwd,
    output logic                 rt_fwd,
    output logic                 stall_req,
    output logic                 busy,
    output logic [CNT_W-1:0]     stall_cnt
);

    // Tracker entries, bit/element 0 = EX (youngest), STAGES-1 = WB (oldest).
    logic [STAGES-1:0]         ent_v;
    logic [STAGES-1:0]         ent_we;
    logic [STAGES-1:0]         ent_ld;
    logic [STAGES-1:0][AW-1:0] ent_waddr;

    logic rs_stall;
    logic rt_stall;
    logic issue_v;

    // Port A resolution: scan oldest to youngest so the youngest match wins.
    always_comb begin
        rs_data  = rf_rs_data;
        rs_fwd   = 1'b0;
        rs_stall = 1'b0;
        if (rs_addr == '0) begin
            rs_data = '0;
        end else begin
            for (int i = STAGES - 1; i >= 0; i--) begin
                if (ent_v[i] && ent_we[i] && (ent_waddr[i] == rs_addr)) begin
                    if (ent_ld[i] && (i < LOAD_READY)) begin
                        // load result not produced yet: operand must wait
                        rs_stall = 1'b1;
                        rs_fwd   = 1'b0;
                        rs_data  = rf_rs_data;
                    end else begin
                        rs_stall = 1'b0;
                        rs_fwd   = 1'b1;
                        rs_data  = stage_wdata[i*DW +: DW];
                    end
                end
            end
        end
    end

    // Port B resolution: same rules as port A.
    always_comb begin
        rt_data  = rf_rt_data;
        rt_fwd   = 1'b0;
        rt_stall = 1'b0;
        if (rt_addr == '0) begin
            rt_data = '0;
        end else begin
            for (int i = STAGES - 1; i >= 0; i--) begin
                if (ent_v[i] && ent_we[i] && (ent_waddr[i] == rt_addr)) begin
                    if (ent_ld[i] && (i < LOAD_READY)) begin
                        rt_stall = 1'b1;
                        rt_fwd   = 1'b0;
                        rt_data  = rf_rt_data;
                    end else begin
                        rt_stall = 1'b0;
                        rt_fwd   = 1'b1;
                        rt_data  = stage_wdata[i*DW +: DW];
                    end
                end
            end
        end
    end

    // Stall request, issue qualification and occupancy flag.
    always_comb begin
        stall_req = (rs_stall | rt_stall) & id_valid;
        issue_v   = id_valid & ~flush & ~stall_req;
        busy      = |ent_v;
    end

    // Tracker shift register and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_v     <= '0;
            ent_ld    <= '0;
            stall_cnt <= '0;
        end else if (!hold) begin
            ent_v     <= {ent_v[STAGES-2:0], issue_v};
            ent_we    <= {ent_we[STAGES-2:0], id_we};
            ent_ld    <= {ent_ld[STAGES-2:0], id_is_load};
            ent_waddr <= {ent_waddr[STAGES-2:0], id_waddr};
            if (stall_req && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: self-checking bench for pipe_scoreboard.
module tb_pipe_scoreboard;

    localparam int STAGES     = 3;
    localparam int AW         = 5;
    localparam int DW         = 32;
    localparam int LOAD_READY = 2;
    localparam int CNT_W      = 4;
    localparam int EXP_W      = CNT_W + 4 + 2 * DW;
    localparam int STALL_BIT  = 2 * DW + 3;

    localparam logic [DW-1:0]    RF_A    = 32'hA000_00A1;
    localparam logic [DW-1:0]    RF_B    = 32'hB000_00B2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ---------------- clock / reset / DUT ----------------
    logic                 clk = 1'b0;
    logic                 rst;
    logic                 hold;
    logic                 flush;
    logic                 id_valid;
    logic                 id_we;
    logic [AW-1:0]        id_waddr;
    logic                 id_is_load;
    logic [AW-1:0]        rs_addr;
    logic [AW-1:0]        rt_addr;
    logic [DW-1:0]        rf_rs_data;
    logic [DW-1:0]        rf_rt_data;
    logic [DW-1:0]        sw [STAGES];
    logic [STAGES*DW-1:0] stage_wdata;
    logic [DW-1:0]        rs_data;
    logic [DW-1:0]        rt_data;
    logic                 rs_fwd;
    logic                 rt_fwd;
    logic                 stall_req;
    logic                 busy;
    logic [CNT_W-1:0]     stall_cnt;

    always #5 clk = ~clk;

    for (genvar g = 0; g < STAGES; g++) begin : g_sw
        assign stage_wdata[g*DW +: DW] = sw[g];
    end

    pipe_scoreboard #(
        .STAGES(STAGES), .AW(AW), .DW(DW), .LOAD_READY(LOAD_READY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_we(id_we), .id_waddr(id_waddr), .id_is_load(id_is_load),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .stage_wdata(stage_wdata), .rs_data(rs_data), .rt_data(rt_data),
        .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .stall_req(stall_req), .busy(busy),
        .stall_cnt(stall_cnt)
    );

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] obs;
    logic [EXP_W-1:0] exp_v;
    logic [CNT_W-1:0] exp_cnt;
    int               n_checks = 0;
    int               n_errors = 0;

    assign obs = {stall_cnt, stall_req, rs_fwd, rt_fwd, busy, rs_data, rt_data};

    // reference tracker for the random test
    logic [STAGES-1:0] m_v;
    logic [STAGES-1:0] m_we;
    logic [STAGES-1:0] m_ld;
    logic [AW-1:0]     m_waddr [STAGES];

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input logic s);
        if (s && !hold && (exp_cnt != CNT_MAX)) exp_cnt = exp_cnt + 1'b1;
        step();
    endtask

    task automatic drive_idle();
        id_valid   = 1'b0;
        id_we      = 1'b0;
        id_waddr   = '0;
        id_is_load = 1'b0;
        rs_addr    = 5'd1;
        rt_addr    = 5'd2;
        hold       = 1'b0;
        flush      = 1'b0;
        rf_rs_data = RF_A;
        rf_rt_data = RF_B;
        for (int i = 0; i < STAGES; i++) sw[i] = {16'h5A5A, 16'(i)};
    endtask

    task automatic drive_id(input logic v, input logic we, input logic [AW-1:0] wa,
                            input logic ld);
        id_valid   = v;
        id_we      = we;
        id_waddr   = wa;
        id_is_load = ld;
    endtask

    task automatic drain();
        drive_idle();
        repeat (STAGES) step();
    endtask

    task automatic push_exp(input logic s, input logic af, input logic bf, input logic b,
                            input logic [DW-1:0] ad, input logic [DW-1:0] bd);
        exp_q.push_back({exp_cnt, s, af, bf, b, ad, bd});
    endtask

    function automatic logic [DW+1:0] model_port(input logic [AW-1:0] a,
                                                 input logic [DW-1:0] rf);
        if (a == '0) return {2'b00, {DW{1'b0}}};
        for (int i = 0; i < STAGES; i++) begin
            if (m_v[i] && m_we[i] && (m_waddr[i] == a)) begin
                if (m_ld[i] && (i < LOAD_READY)) return {2'b10, rf};
                return {2'b01, sw[i]};
            end
        end
        return {2'b00, rf};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            id_valid   = 1'($urandom_range(0, 1));
            id_we      = 1'($urandom_range(0, 1));
            id_waddr   = AW'($urandom_range(0, 31));
            id_is_load = 1'($urandom_range(0, 1));
            hold       = 1'($urandom_range(0, 1));
            flush      = 1'($urandom_range(0, 1));
            rs_addr    = AW'($urandom_range(1, 31));
            rt_addr    = AW'($urandom_range(1, 31));
            rf_rs_data = $urandom;
            rf_rt_data = $urandom;
            for (int i = 0; i < STAGES; i++) sw[i] = $urandom;
            step();
        end
        exp_cnt = '0;
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, rf_rs_data, rf_rt_data);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL reset: got %h required %h", obs, exp_v);
        end
        rst = 1'b0;
        drive_idle();
        step();
    endtask

    task automatic test_alu_chain();
        drain();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin
                    drive_id(1'b1, 1'b1, 5'd3, 1'b0);
                    push_exp(1'b0, 1'b0, 1'b0, 1'b0, RF_A, RF_B);
                end
                1: begin
                    drive_id(1'b1, 1'b1, 5'd3, 1'b0);
                    rs_addr = 5'd3;
                    sw[0]   = 32'h0000_1234;
                    push_exp(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1234, RF_B);
                end
                default: begin
                    drive_id(1'b0, 1'b0, 5'd0, 1'b0);
                    rs_addr = 5'd3;
                    rt_addr = 5'd3;
                    sw[0]   = 32'h0000_AAAA;
                    sw[1]   = 32'h0000_BBBB;
                    push_exp(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_AAAA, 32'h0000_AAAA);
                end
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL alu_chain[%0d]: got %h required %h", k, obs, exp_v);
            end
            advance(exp_v[STALL_BIT]);
        end
    endtask

    task automatic test_load_use();
        drain();
        sw[2] = 32'h5555_0005;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                drive_id(1'b1, 1'b1, 5'd5, 1'b1);
                push_exp(1'b0, 1'b0, 1'b0, 1'b0, RF_A, RF_B);
            end else begin
                drive_id(1'b1, 1'b1, 5'd9, 1'b0);
                rt_addr = 5'd5;
                if (k < 3) push_exp(1'b1, 1'b0, 1'b0, 1'b1, RF_A, RF_B);
                else       push_exp(1'b0, 1'b0, 1'b1, 1'b1, RF_A, 32'h5555_0005);
            end
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL load_use[%0d]: got %h required %h", k, obs, exp_v);
            end
            advance(exp_v[STALL_BIT]);
        end
    endtask

    task automatic test_reg_zero();
        drain();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                drive_id(1'b1, 1'b1, 5'd0, 1'b1);
                push_exp(1'b0, 1'b0, 1'b0, 1'b0, RF_A, RF_B);
            end else begin
                drive_id(1'b1, 1'b0, 5'd0, 1'b0);
                rs_addr = 5'd0;
                rt_addr = 5'd0;
                sw[0]   = 32'hDEAD_BEEF;
                push_exp(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
            end
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL reg_zero[%0d]: got %h required %h", k, obs, exp_v);
            end
            advance(exp_v[STALL_BIT]);
        end
    endtask

    task automatic test_hold_stall();
        drain();
        sw[2] = 32'h6666_0006;
        for (int k = 0; k < 7; k++) begin
            if (k == 0) begin
                drive_id(1'b1, 1'b1, 5'd5, 1'b1);
                push_exp(1'b0, 1'b0, 1'b0, 1'b0, RF_A, RF_B);
            end else begin
                drive_id(1'b1, 1'b1, 5'd9, 1'b0);
                rt_addr = 5'd5;
                hold    = (k <= 3);
                if (k < 6) push_exp(1'b1, 1'b0, 1'b0, 1'b1, RF_A, RF_B);
                else       push_exp(1'b0, 1'b0, 1'b1, 1'b1, RF_A, 32'h6666_0006);
            end
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL hold_stall[%0d]: got %h required %h", k, obs, exp_v);
            end
            advance(exp_v[STALL_BIT]);
        end
    endtask

    task automatic test_flush_drain();
        drain();
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: begin
                    drive_id(1'b1, 1'b1, 5'd7, 1'b0);
                    flush = 1'b1;
                    push_exp(1'b0, 1'b0, 1'b0, 1'b0, RF_A, RF_B);
                end
                1: begin
                    drive_id(1'b1, 1'b1, 5'd8, 1'b0);
                    flush   = 1'b0;
                    rs_addr = 5'd7;
                    push_exp(1'b0, 1'b0, 1'b0, 1'b0, RF_A, RF_B);
                end
                default: begin
                    drive_idle();
                    rs_addr = 5'd7;
                    push_exp(1'b0, 1'b0, 1'b0, (k < 5), RF_A, RF_B);
                end
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL flush_drain[%0d]: got %h required %h", k, obs, exp_v);
            end
            advance(exp_v[STALL_BIT]);
        end
    endtask

    task automatic test_random();
        logic [DW+1:0] pa;
        logic [DW+1:0] pb;
        logic          s;
        drain();
        m_v  = '0;
        m_we = '0;
        m_ld = '0;
        for (int i = 0; i < STAGES; i++) m_waddr[i] = '0;
        for (int k = 0; k < 300; k++) begin
            id_valid   = 1'($urandom_range(0, 1));
            id_we      = 1'($urandom_range(0, 1));
            id_waddr   = AW'($urandom_range(0, 7));
            id_is_load = ($urandom_range(0, 2) == 0);
            hold       = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            rs_addr    = AW'($urandom_range(0, 7));
            rt_addr    = AW'($urandom_range(0, 7));
            rf_rs_data = $urandom;
            rf_rt_data = $urandom;
            for (int i = 0; i < STAGES; i++) sw[i] = $urandom;
            pa = model_port(rs_addr, rf_rs_data);
            pb = model_port(rt_addr, rf_rt_data);
            s  = (pa[DW+1] | pb[DW+1]) & id_valid;
            push_exp(s, pa[DW], pb[DW], |m_v, pa[DW-1:0], pb[DW-1:0]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL random[%0d]: got %h required %h", k, obs, exp_v);
            end
            if (!hold) begin
                for (int i = STAGES - 1; i > 0; i--) begin
                    m_v[i]     = m_v[i-1];
                    m_we[i]    = m_we[i-1];
                    m_ld[i]    = m_ld[i-1];
                    m_waddr[i] = m_waddr[i-1];
                end
                m_v[0]     = id_valid & ~flush & ~s;
                m_we[0]    = id_we;
                m_ld[0]    = id_is_load;
                m_waddr[0] = id_waddr;
            end
            advance(s);
        end
    endtask

    task automatic test_saturation();
        drain();
        sw[2] = 32'h7777_0007;
        for (int k = 0; k < 30; k++) begin
            drive_id(1'b1, 1'b1, 5'd5, 1'b1);
            rt_addr = 5'd5;
            if (k == 0)          push_exp(1'b0, 1'b0, 1'b0, 1'b0, RF_A, RF_B);
            else if (k % 3 != 0) push_exp(1'b1, 1'b0, 1'b0, 1'b1, RF_A, RF_B);
            else                 push_exp(1'b0, 1'b0, 1'b1, 1'b1, RF_A, 32'h7777_0007);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL saturation[%0d]: got %h required %h", k, obs, exp_v);
            end
            advance(exp_v[STALL_BIT]);
        end
        @(negedge clk);
        n_checks++;
        if (stall_cnt !== CNT_MAX) begin
            n_errors++;
            $display("FAIL saturation_final: stall_cnt got %h required %h", stall_cnt, CNT_MAX);
        end
        drain();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        rst     = 1'b1;
        exp_cnt = '0;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_reg_zero();
        test_hold_stall();
        test_flush_drain();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
